mcu_time_scheduler: RTL and testbench
=====================================

# mcu_time_scheduler

Time-unit scheduler for the multi-MCU design: it gates instruction execution for each microcontroller core, tracks each core's `slp` countdown, and generates the one-cycle `posedge_big_clk` time-unit pulse. The pulse is issued once every core is asleep, or when a per-time-unit step budget runs out. It replaces the free-running bench-generated big clock and sits beside the MCU cores inside the top-level design.

## Interface

**Parameters**
- `NUM_CORES`, default 2: number of MCU cores scheduled.
- `VAL_W`, default 11: width of the signed sleep operand, matching the 11-bit signal width.
- `MAX_STEPS`, default 64: run cycles allowed per time unit before a forced tick.
- `TIME_W`, default 16: width of the time-unit counter.

**Ports**
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: scheduler run permission. While low, the scheduler holds in IDLE.
- `sleep_req`, input, `NUM_CORES`: core *i* executed `slp` this cycle.
- `sleep_val`, input, `NUM_CORES*VAL_W`: signed sleep operand per core, packed with core 0 in the LSBs.
- `core_run`, output, `NUM_CORES`: execute enable per core.
- `posedge_big_clk`, output, 1: one-cycle time-unit pulse.
- `time_count`, output, `TIME_W`: number of completed time units.
- `overrun`, output, 1: sticky flag; at least one tick was forced by the step budget.

## Operation

**States.** IDLE, RUN, TICK.

**Reset.** On reset, all outputs are 0, all sleep counters are 0, the step counter is 0, and the state is IDLE.

**IDLE.**
- `core_run` = 0.
- Moves to RUN on the cycle after `enable` is sampled high.

**RUN.**
- `core_run[i]` = (sleep_cnt[i] == 0).
- `step_cnt` increments every RUN cycle.

**Accepting a sleep request.**
- `sleep_req[i]` is accepted only when `core_run[i]` is 1 in the same cycle; otherwise it is ignored.
- The operand is clamped before loading: a value ≤ 0 becomes 1, and a value > 999 becomes 999.
- The clamped value is loaded into sleep_cnt[i].

**RUN exit.**
- Go to TICK when every core's next-state sleep_cnt is nonzero. This check includes requests accepted in the current cycle.
- Also go to TICK when `step_cnt` reaches MAX_STEPS−1 with some core still awake. In that case `overrun` is set and stays set until reset.
- If `enable` is sampled low in RUN, go to IDLE. Sleep counters are preserved.

**TICK (exactly one cycle).**
- `posedge_big_clk` = 1 and `core_run` = 0.
- At the end of the cycle: every nonzero sleep_cnt decrements by 1, `time_count` increments (wrapping modulo 2^TIME_W), and `step_cnt` clears.
- Next state is RUN, or IDLE if `enable` is low.

**Simultaneous events.**
- Several cores may sleep in the same cycle; all requests are accepted.
- A budget-forced tick and an all-asleep tick in the same cycle count as a normal tick: `overrun` is not set.

**Reset mid-operation.** Asynchronous return to the reset values above. Any pending sleeps are discarded.

## Timing

**Latencies.**
- `sleep_req` accepted at edge *t*: `core_run[i]` falls in the cycle after *t*.
- Last core sleeps at edge *t*: `posedge_big_clk` is high for cycle *t+1* only.
- Core slept with value *u*: it is re-enabled in the cycle after the *u*-th TICK.

**Pulse properties.**
- `posedge_big_clk` never stays high for two consecutive cycles.
- Minimum spacing between pulses is 2 cycles: TICK, RUN, TICK.

**Output decode.** `core_run` and `posedge_big_clk` are registered-state decodes. There is no combinational path from `sleep_req` to any output.

**Deadlock bound.** The step budget guarantees a tick at least every MAX_STEPS+1 cycles while enabled.

## Structure

**Shared package (`mcu_sched_pkg`).**
- State enum {IDLE, RUN, TICK}.
- `SLEEP_MAX` = 999.
- `SLEEP_MIN` = 1.
- The clamp function for signed VAL_W operands.

**Sub-module `sleep_counter`.** Instantiated once per core.
- Inputs: `load` with a clamped value, and `dec`.
- Outputs: count and `is_zero`.

**Top level.** Contains the FSM, step counter, time counter and overrun flag.

## Test plan

1. **Single core, one-unit sleep.** Reset, `enable`=1, core0 issues `slp 1` on its first run cycle, core1 issues `slp 1` the next cycle → one TICK pulse follows; `time_count`=1; both `core_run` return to 1 the cycle after TICK.
2. **Multi-unit sleep with clamping.** Core0 `slp 3`, core1 `slp 1` repeatedly → core0 stays gated through 3 TICKs. A core0 operand of −5 or 0 behaves as 1; an operand of 1023 loads 999.
3. **Simultaneous sleep.** Both cores assert `sleep_req` in the same cycle → exactly one TICK in the next cycle, with no extra RUN cycle.
4. **Budget overrun.** Core1 never sleeps, MAX_STEPS=64 → a forced TICK every 65 cycles; `overrun`=1 and stays 1; core0's sleep still decrements on each forced tick.
5. **Ignored request.** `sleep_req[0]` asserted while core0 is gated → sleep_cnt[0] is unchanged.
6. **Mid-operation reset and enable drop.** Reset asserted between edges mid-RUN with sleeps pending → all outputs 0 immediately; after release, IDLE until `enable`. Separately, dropping `enable` in RUN → IDLE with counts preserved, and the run resumes correctly when re-enabled.

Source files
------------

// File: rtl/mcu_sched_pkg.sv
// Shared types and helpers for the MCU time-unit scheduler.
// Sleep operands are clamped into the 1..999 range before loading.
package mcu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TICK
  } sched_state_e;

  localparam int SLEEP_MAX = 999;
  localparam int SLEEP_MIN = 1;
  localparam int CNT_W     = 10;

  function automatic logic [CNT_W-1:0] clamp_sleep(input int v);
    logic [CNT_W-1:0] r;
    if (v <= 0)
      r = CNT_W'(SLEEP_MIN);
    else if (v > SLEEP_MAX)
      r = CNT_W'(SLEEP_MAX);
    else
      r = CNT_W'(v);
    return r;
  endfunction

endpackage

// File: rtl/mcu_time_scheduler_sleep_counter.sv
// Per-core sleep countdown in time units.
// A load writes a clamped value; a dec steps a nonzero count down.
module sleep_counter
  import mcu_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_zero
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // next count: load wins, else decrement toward zero
  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (dec && count_q != '0)
      count_d = count_q - CNT_W'(1);
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count   = count_q;
  assign is_zero = (count_q == '0);

endmodule

// File: rtl/mcu_time_scheduler.sv
// Time-unit scheduler: gates MCU cores and issues the big-clock
// pulse once all cores sleep or the per-unit step budget expires.
module mcu_time_scheduler
  import mcu_sched_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int VAL_W     = 11,
  parameter int MAX_STEPS = 64,
  parameter int TIME_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CORES-1:0]       sleep_req,
  input  logic [NUM_CORES*VAL_W-1:0] sleep_val,
  output logic [NUM_CORES-1:0]       core_run,
  output logic                       posedge_big_clk,
  output logic [TIME_W-1:0]          time_count,
  output logic                       overrun
);

  localparam int STEP_W = $clog2(MAX_STEPS) + 1;

  sched_state_e      state_d, state_q;
  logic [STEP_W-1:0] step_d, step_q;
  logic [TIME_W-1:0] time_d, time_q;
  logic              ovr_d, ovr_q;

  logic [NUM_CORES-1:0] cnt_zero;
  logic [NUM_CORES-1:0] accept;
  logic [NUM_CORES-1:0] next_asleep;
  logic                 dec;
  logic [CNT_W-1:0]     load_val [NUM_CORES];
  logic [CNT_W-1:0]     cnt      [NUM_CORES];

  assign core_run        = (state_q == RUN) ? cnt_zero : '0;
  assign posedge_big_clk = (state_q == TICK);
  assign dec             = (state_q == TICK);
  assign accept          = sleep_req & core_run;
  assign next_asleep     = ~cnt_zero | accept;
  assign time_count      = time_q;
  assign overrun         = ovr_q;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic signed [VAL_W-1:0] op;
    assign op          = sleep_val[g*VAL_W +: VAL_W];
    assign load_val[g] = clamp_sleep(int'(op));

    sleep_counter u_cnt (
      .clk     (clk),
      .rst     (reset),
      .load    (accept[g]),
      .load_val(load_val[g]),
      .dec     (dec),
      .count   (cnt[g]),
      .is_zero (cnt_zero[g])
    );
  end

  // next state, step budget, time counter and overrun flag
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    time_d  = time_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (enable)
          state_d = RUN;
      end
      RUN: begin
        step_d = step_q + STEP_W'(1);
        if (!enable)
          state_d = IDLE;
        else if (&next_asleep)
          state_d = TICK;
        else if (step_q == STEP_W'(MAX_STEPS - 1)) begin
          state_d = TICK;
          ovr_d   = 1'b1;
        end
      end
      TICK: begin
        time_d  = time_q + TIME_W'(1);
        step_d  = '0;
        state_d = enable ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // scheduler registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      time_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      time_q  <= time_d;
      ovr_q   <= ovr_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{cnt[0]};

endmodule

// File: tb/tb_mcu_time_scheduler.sv
// Directed bench for mcu_time_scheduler.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_mcu_time_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  sleep_req = '0;
  logic [21:0] sleep_val = '0;
  logic [1:0]  core_run;
  logic        posedge_big_clk;
  logic [15:0] time_count;
  logic        overrun;

  int n_checks = 0;
  int n_fail = 0;

  mcu_time_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .sleep_req      (sleep_req),
    .sleep_val      (sleep_val),
    .core_run       (core_run),
    .posedge_big_clk(posedge_big_clk),
    .time_count     (time_count),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] r, input int v0, input int v1);
    sleep_req = r;
    sleep_val = {11'(v1), 11'(v0)};
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int cyc;

    // reset state
    step();
    check("rst_run", 32'(core_run), 0);
    check("rst_pbc", 32'(posedge_big_clk), 0);
    check("rst_time", 32'(time_count), 0);
    check("rst_ovr", 32'(overrun), 0);

    // test 1: staggered one-unit sleeps
    reset = 1'b0;
    enable = 1'b1;
    step();
    check("t1_run0", 32'(core_run), 3);
    req(2'b01, 1, 0);
    step();
    check("t1_gate0", 32'(core_run), 2);
    check("t1_nopbc", 32'(posedge_big_clk), 0);
    req(2'b10, 0, 1);
    step();
    check("t1_pbc", 32'(posedge_big_clk), 1);
    check("t1_tickrun", 32'(core_run), 0);
    req(2'b00, 0, 0);
    step();
    check("t1_pbc_off", 32'(posedge_big_clk), 0);
    check("t1_wake", 32'(core_run), 3);
    check("t1_time", 32'(time_count), 1);

    // test 3: simultaneous sleep
    req(2'b11, 1, 1);
    step();
    check("t3_pbc", 32'(posedge_big_clk), 1);
    req(2'b00, 0, 0);
    step();
    check("t3_wake", 32'(core_run), 3);
    check("t3_time", 32'(time_count), 2);

    // test 2 + 5: slp 3 on core0, ignored request while gated
    req(2'b11, 3, 1);
    step();
    check("t2_pbc_a", 32'(posedge_big_clk), 1);
    req(2'b00, 0, 0);
    step();
    check("t2_gate_a", 32'(core_run), 2);
    req(2'b10, 0, 1);
    step();
    check("t2_pbc_b", 32'(posedge_big_clk), 1);
    req(2'b00, 0, 0);
    step();
    check("t2_gate_b", 32'(core_run), 2);
    req(2'b11, 5, 1);
    step();
    check("t5_pbc_c", 32'(posedge_big_clk), 1);
    req(2'b00, 0, 0);
    step();
    check("t5_ignored", 32'(core_run), 3);
    check("t2_time", 32'(time_count), 5);

    // clamp: -5 and 0 behave as 1
    req(2'b11, -5, 1);
    step();
    req(2'b00, 0, 0);
    step();
    check("clamp_neg", 32'(core_run), 3);
    req(2'b11, 0, 1);
    step();
    req(2'b00, 0, 0);
    step();
    check("clamp_zero", 32'(core_run), 3);
    check("clamp_time", 32'(time_count), 7);

    // clamp: 1023 loads 999, count ticks until core0 wakes
    req(2'b11, 1023, 1);
    step();
    n = 0;
    for (int g = 0; g < 2500; g++) begin
      if (posedge_big_clk) n++;
      if (core_run[0]) break;
      req({core_run[1], 1'b0}, 0, 1);
      step();
    end
    req(2'b00, 0, 0);
    check("clamp_1023", 32'(n), 999);
    check("clamp_1023_time", 32'(time_count), 1006);
    check("no_ovr_yet", 32'(overrun), 0);

    // test 4: budget overrun, core1 stays awake
    req(2'b01, 2, 0);
    cyc = 0;
    for (int g = 0; g < 200; g++) begin
      step();
      req(2'b00, 0, 0);
      cyc++;
      if (posedge_big_clk) break;
    end
    check("t4_first_gap", 32'(cyc), 64);
    check("t4_ovr", 32'(overrun), 1);
    check("t4_tickrun", 32'(core_run), 0);
    cyc = 0;
    for (int g = 0; g < 200; g++) begin
      step();
      cyc++;
      if (cyc == 1)
        check("t4_dec1", 32'(core_run), 2);
      if (posedge_big_clk) break;
    end
    check("t4_period", 32'(cyc), 65);
    check("t4_ovr_sticky", 32'(overrun), 1);
    step();
    check("t4_dec2", 32'(core_run), 3);
    check("t4_time", 32'(time_count), 1008);

    // test 6a: async reset mid-run with sleep pending
    req(2'b01, 5, 0);
    step();
    req(2'b00, 0, 0);
    check("t6_gated", 32'(core_run), 2);
    #3;
    reset = 1'b1;
    #1;
    check("t6_rst_run", 32'(core_run), 0);
    check("t6_rst_time", 32'(time_count), 0);
    check("t6_rst_ovr", 32'(overrun), 0);
    enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    check("t6_idle", 32'(core_run), 0);
    enable = 1'b1;
    step();
    check("t6_discard", 32'(core_run), 3);

    // budget expiry together with all-asleep is a normal tick
    n = 0;
    for (int g = 0; g < 63; g++) begin
      step();
      if (posedge_big_clk) n++;
    end
    check("sim_no_early", 32'(n), 0);
    req(2'b11, 1, 1);
    step();
    req(2'b00, 0, 0);
    check("sim_pbc", 32'(posedge_big_clk), 1);
    check("sim_no_ovr", 32'(overrun), 0);
    step();
    check("sim_time", 32'(time_count), 1);

    // test 6b: enable drop keeps counts
    req(2'b01, 2, 0);
    step();
    req(2'b00, 0, 0);
    check("t6b_gated", 32'(core_run), 2);
    enable = 1'b0;
    step();
    check("t6b_idle", 32'(core_run), 0);
    step();
    check("t6b_idle_pbc", 32'(posedge_big_clk), 0);
    enable = 1'b1;
    step();
    check("t6b_kept", 32'(core_run), 2);
    req(2'b10, 0, 1);
    step();
    req(2'b00, 0, 0);
    check("t6b_pbc1", 32'(posedge_big_clk), 1);
    step();
    check("t6b_still", 32'(core_run), 2);
    req(2'b10, 0, 1);
    step();
    req(2'b00, 0, 0);
    step();
    check("t6b_wake", 32'(core_run), 3);
    check("t6b_time", 32'(time_count), 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
